// File: rtl/seg_pkg.sv
// Shared 7-segment definitions for the counter display: active-high a-g patterns
// for BCD digits 0-9, the blank pattern and the BCD-to-segment lookup.
package seg_pkg;

    // Bit order is g..a in [6:0]; a lit segment is 1 before any output inversion.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Full seg_led word (dp + g..a) with everything dark, active-high.
    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_counter_display_bcd_updown_counter.sv
// Cascaded N-digit BCD up/down counter with clamped parallel load and a
// one-cycle wrap pulse when the count rolls over in either direction.
module bcd_updown_counter
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    tick,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap
);

    logic [4*NUM_DIGITS-1:0] next_val;
    logic [4*NUM_DIGITS-1:0] clamp_val;
    logic                    carry;

    // carry doubles as borrow when counting down; surviving the top digit means wrap.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_val  = count_bcd;
        clamp_val = load_val;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (clamp_val[4*i +: 4] > 4'd9) begin
                clamp_val[4*i +: 4] = 4'd9;
            end
            if (carry) begin
                if (up_dn) begin
                    if (count_bcd[4*i +: 4] >= 4'd9) begin
                        next_val[4*i +: 4] = 4'd0;
                    end else begin
                        next_val[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (count_bcd[4*i +: 4] == 4'd0) begin
                        next_val[4*i +: 4] = 4'd9;
                    end else begin
                        next_val[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count_bcd <= clamp_val;
            end else if (tick) begin
                count_bcd <= next_val;
                wrap      <= carry;
            end
        end
    end

endmodule

// File: rtl/seg_counter_display.sv
// N-digit BCD counter with a multiplexed 7-segment driver: count and scan
// prescalers, leading-zero blanking, decimal points and output polarity.
module seg_counter_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int CLK_HZ      = 50_000_000,
    parameter int COUNT_HZ    = 10,
    parameter int SCAN_HZ     = 1000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [7:0]              seg_led,
    output logic [NUM_DIGITS-1:0]   seg_sel
);

    localparam int CNT_DIV  = CLK_HZ / COUNT_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(CNT_DIV);
    localparam int SCAN_W   = $clog2(SCAN_DIV);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [7:0]            LED_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACT_LOW ? '1 : '0;

    logic [CNT_W-1:0]      cnt_presc;
    logic [SCAN_W-1:0]     scan_presc;
    logic [IDX_W-1:0]      scan_idx;
    logic                  tick;
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] sel_raw;
    logic [7:0]            led_raw;

    assign tick = en && (cnt_presc == CNT_W'(CNT_DIV - 1));

    // A load restarts the count period so the loaded value is shown for a full tick.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_presc <= '0;
        end else if (load || tick) begin
            cnt_presc <= '0;
        end else if (en) begin
            cnt_presc <= cnt_presc + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scan_presc <= '0;
            scan_idx   <= '0;
        end else if (scan_presc == SCAN_W'(SCAN_DIV - 1)) begin
            scan_presc <= '0;
            scan_idx   <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            scan_presc <= scan_presc + SCAN_W'(1);
        end
    end

    bcd_updown_counter #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_counter (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tick     (tick),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count_bcd(count_bcd),
        .wrap     (wrap)
    );

    // Blank digit i>0 when it and every higher digit are zero; walk from the top down.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (count_bcd[4*i +: 4] == 4'd0);
            blank[i]   = BLANK_LZ && (i != 0) && zero_above;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        sel_raw   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_digit  = count_bcd[4*i +: 4];
                cur_blank  = blank[i];
                cur_dp     = dp_mask[i];
                sel_raw[i] = 1'b1;
            end
        end
        led_raw = {cur_dp, cur_blank ? SEG_BLANK : bcd_to_seg(cur_digit)};
    end

    // Polarity is applied only here so all internal logic stays active-high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seg_led <= LED_IDLE;
            seg_sel <= SEL_IDLE;
        end else begin
            seg_led <= SEG_ACT_LOW ? ~led_raw : led_raw;
            seg_sel <= SEL_ACT_LOW ? ~sel_raw : sel_raw;
        end
    end

endmodule
